// File: rtl/anton_neopixel_pixel_serializer_pkg.sv
// Shared types and defaults for the NeoPixel pixel serializer.
//  - serState_t          : fetch FSM states (IDLE / FETCH)
//  - *_DEFAULT           : default buffer size and high-time step counts
//  - RD_DATA_BITS        : width of the pixel buffer read data
//  - PIXEL_BITS          : serialized GRB pixel width
//  - bufferBits()        : address width needed for a given last byte address
package anton_neopixel_pixel_serializer_pkg;

    typedef enum logic [0:0] {
        SER_STATE_IDLE  = 1'b0,
        SER_STATE_FETCH = 1'b1
    } serState_t;

    localparam int BUFFER_END_DEFAULT  = 255;
    localparam int HIGH0_STEPS_DEFAULT = 2;
    localparam int HIGH1_STEPS_DEFAULT = 5;
    localparam int RD_DATA_BITS        = 32;
    localparam int PIXEL_BITS          = 24;

    function automatic int bufferBits(input int bufferEnd);
        return $clog2(bufferEnd + 1);
    endfunction

endpackage

// File: rtl/anton_neopixel_pixel_serializer_if.sv
// Pixel buffer read port (request/ack).
//  rdReq  : request, held until rdAck
//  rdAddr : byte address, stable while rdReq=1
//  rdAck  : read data valid this cycle
//  rdData : read data word (8-bit mode uses [7:0])
// master = serializer side, slave = pixel buffer side.
interface anton_neopixel_pixel_serializer_if
    import anton_neopixel_pixel_serializer_pkg::*;
#(
    parameter int ADDR_BITS = 8
);
    logic                    rdReq;
    logic [ADDR_BITS-1:0]    rdAddr;
    logic                    rdAck;
    logic [RD_DATA_BITS-1:0] rdData;

    modport master (output rdReq, output rdAddr, input rdAck, input rdData);
    modport slave  (input rdReq, input rdAddr, output rdAck, output rdData);
endinterface

// File: rtl/anton_neopixel_color_expand.sv
// Combinational pixel format conversion.
//  laneWord : low 24 bits of the buffer read word
//  mode32   : 1 = word already holds {G,R,B}; 0 = [7:0] holds RGB332 (RRRGGGBB)
//  grb      : 24-bit {G8,R8,B8}
// Channels are widened by bit replication so full scale maps to 0xFF.
module anton_neopixel_color_expand
    import anton_neopixel_pixel_serializer_pkg::*;
(
    input  logic [PIXEL_BITS-1:0] laneWord,
    input  logic                  mode32,
    output logic [PIXEL_BITS-1:0] grb
);
    logic [2:0] red3;
    logic [2:0] green3;
    logic [1:0] blue2;
    logic [7:0] red8;
    logic [7:0] green8;
    logic [7:0] blue8;

    assign red3   = laneWord[7:5];
    assign green3 = laneWord[4:2];
    assign blue2  = laneWord[1:0];

    assign red8   = {red3, red3, red3[2:1]};
    assign green8 = {green3, green3, green3[2:1]};

    // Blue has only two bits, so it repeats four times.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_blueRep
            assign blue8[2*gi +: 2] = blue2;
        end
    endgenerate

    assign grb = mode32 ? laneWord : {green8, red8, blue8};
endmodule

// File: rtl/anton_neopixel_pixel_serializer.sv
// NeoPixel pixel serializer: fetches each pixel from the pixel buffer at the start of
// the pixel and drives an 8-step-per-bit waveform on neoData (registered, 1 clock latency).
//  clk6_4mhz, rst           : stream clock, asynchronous active-high reset
//  regCtrlInit              : sync clear of pixel latch, underrun flag and neoData
//  regCtrl32bit             : 1 = 32-bit word per pixel, 0 = RGB332 byte per pixel
//  streamOutput/streamReset : sequencer transmit / latch state
//  bitPatternIndex          : sub-bit step 0..7
//  pixelBitIndex            : pixel bit 0..23 (0 = MSB)
//  pixelIndex               : byte address of current pixel
//  rdBus                    : pixel buffer read port (master)
//  neoData                  : serial line to the strip
//  underrun                 : sticky, a pixel missed its fetch deadline
module anton_neopixel_pixel_serializer
    import anton_neopixel_pixel_serializer_pkg::*;
#(
    parameter int  BUFFER_END  = BUFFER_END_DEFAULT,
    parameter int  HIGH0_STEPS = HIGH0_STEPS_DEFAULT,
    parameter int  HIGH1_STEPS = HIGH1_STEPS_DEFAULT,
    localparam int BUFFER_BITS = bufferBits(BUFFER_END)
)(
    input  logic                   clk6_4mhz,
    input  logic                   rst,
    input  logic                   regCtrlInit,
    input  logic                   regCtrl32bit,
    input  logic                   streamOutput,
    input  logic                   streamReset,
    input  logic [2:0]             bitPatternIndex,
    input  logic [4:0]             pixelBitIndex,
    input  logic [BUFFER_BITS-1:0] pixelIndex,
    anton_neopixel_pixel_serializer_if.master rdBus,
    output logic                   neoData,
    output logic                   underrun
);
    localparam logic [2:0] HIGH0_STEP    = 3'(HIGH0_STEPS);
    localparam logic [2:0] HIGH1_STEP    = 3'(HIGH1_STEPS);
    // Last step at which bit 0 looks identical for '0' and '1'; data must be in by then.
    localparam logic [2:0] DEADLINE_STEP = 3'(HIGH0_STEPS - 1);

    serState_t             stateReg;
    serState_t             stateNext;
    logic                  lateReg;
    logic                  underrunReg;
    logic                  neoDataReg;
    logic [PIXEL_BITS-1:0] pixelDataReg;
    logic [BUFFER_BITS-1:0] rdAddrReg;

    logic                  pixelStart;
    logic                  startFetch;
    logic                  reqComb;
    logic                  captureEn;
    logic                  captureValid;
    logic                  missDeadline;
    logic                  ignoredStart;
    logic                  bitVal;
    logic                  neoDataNext;
    logic [4:0]            bitSel;
    logic [2:0]            highSteps;
    logic [PIXEL_BITS-1:0] expandedPixel;

    anton_neopixel_color_expand uColorExpand (
        .laneWord (rdBus.rdData[PIXEL_BITS-1:0]),
        .mode32   (regCtrl32bit),
        .grb      (expandedPixel)
    );

    assign pixelStart = streamOutput && (pixelBitIndex == 5'd0) && (bitPatternIndex == 3'd0);

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            stateReg <= SER_STATE_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        reqComb    = 1'b0;
        startFetch = 1'b0;
        captureEn  = 1'b0;
        case (stateReg)
            SER_STATE_IDLE: begin
                if (pixelStart) begin
                    reqComb    = 1'b1;
                    startFetch = 1'b1;
                    if (rdBus.rdAck) begin
                        captureEn = 1'b1;
                    end else begin
                        stateNext = SER_STATE_FETCH;
                    end
                end
            end
            SER_STATE_FETCH: begin
                reqComb = 1'b1;
                if (rdBus.rdAck) begin
                    captureEn = 1'b1;
                    stateNext = SER_STATE_IDLE;
                end
            end
            default: stateNext = SER_STATE_IDLE;
        endcase
    end

    // An ack in the deadline cycle itself still wins: missDeadline requires !rdAck.
    assign missDeadline = (stateReg == SER_STATE_FETCH) && !rdBus.rdAck && !lateReg &&
                          (pixelBitIndex == 5'd0) && (bitPatternIndex == DEADLINE_STEP);
    assign ignoredStart = (stateReg == SER_STATE_FETCH) && pixelStart;
    // A late ack is consumed but its data is thrown away.
    assign captureValid = captureEn && ((stateReg == SER_STATE_IDLE) || !lateReg);

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            lateReg   <= 1'b0;
            rdAddrReg <= '0;
        end else begin
            if (startFetch) begin
                rdAddrReg <= pixelIndex;
            end
            if (startFetch && !rdBus.rdAck) begin
                lateReg <= 1'b0;
            end else if (missDeadline || ignoredStart) begin
                lateReg <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            underrunReg  <= 1'b0;
            pixelDataReg <= '0;
        end else if (regCtrlInit) begin
            underrunReg  <= 1'b0;
            pixelDataReg <= '0;
        end else begin
            if (missDeadline || ignoredStart) begin
                underrunReg <= 1'b1;
            end
            // Missed pixels go out black from the first step where bit values differ.
            if (captureValid) begin
                pixelDataReg <= expandedPixel;
            end else if (missDeadline || ignoredStart) begin
                pixelDataReg <= '0;
            end
        end
    end

    assign bitSel      = 5'd23 - pixelBitIndex;
    assign bitVal      = (pixelBitIndex <= 5'd23) ? pixelDataReg[bitSel] : 1'b0;
    assign highSteps   = bitVal ? HIGH1_STEP : HIGH0_STEP;
    assign neoDataNext = streamOutput && !streamReset && (bitPatternIndex < highSteps);

    always_ff @(posedge clk6_4mhz or posedge rst) begin
        if (rst) begin
            neoDataReg <= 1'b0;
        end else if (regCtrlInit) begin
            neoDataReg <= 1'b0;
        end else begin
            neoDataReg <= neoDataNext;
        end
    end

    // The request address is the live pixelIndex in the request cycle, then the held copy.
    assign rdBus.rdReq  = reqComb && !rst;
    assign rdBus.rdAddr = (startFetch && !rst) ? pixelIndex : rdAddrReg;
    assign neoData      = neoDataReg;
    assign underrun     = underrunReg;
endmodule
